rptr_empty: RTL

Read-side pointer and empty-flag generator for the dual-clock asynchronous FIFO, running entirely in the read clock domain. It keeps the binary read address and Gray-coded read pointer, and compares the Gray pointer with the write pointer after it has been synchronized into the read domain. From that comparison it produces a registered empty flag, a fill level, an almost-empty flag, a read-data-valid strobe aligned to the synchronous RAM, and an optional sticky underflow flag. It is the counterpart of the write-side pointer/full logic; `rptr` feeds the read-to-write synchronizer.

---
 rtl/rptr_empty.sv | 99 +++++++++
 1 files changed

// File: rtl/rptr_empty.sv
// rptr_empty: read-side pointer and empty-flag logic for a dual-clock FIFO.
// Runs entirely in the rclk domain and compares its Gray read pointer with
// the synchronized Gray write pointer.
//
// Ports:
//   rclk, rrst_n   read clock, async active-low reset
//   r_req          read request
//   rq2_wptr       Gray write pointer, already synchronized to rclk
//   rerr_clr       clears the sticky underflow flag
//   raddr          RAM read address (low bits of binary read pointer)
//   rptr           registered Gray read pointer, to the write domain
//   rempty         registered empty flag
//   rvalid         RAM read data valid (one cycle after an accepted read)
//   rlevel         registered fill level, 0..2^ADDRSIZE
//   raempty        registered almost-empty flag (rlevel <= AEMPTY_TH)
//   rerr           sticky underflow flag
//
// Build option: define RPTR_UNDERFLOW_EN to build the rerr register;
// otherwise rerr is tied low and rerr_clr is ignored.
module rptr_empty #(
    parameter int ADDRSIZE  = 4,
    parameter int AEMPTY_TH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                r_req,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic                rerr_clr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                rvalid,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                raempty,
    output logic                rerr
);

    localparam logic [ADDRSIZE:0] AE_TH = AEMPTY_TH[ADDRSIZE:0];

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] wbin_s;
    logic [ADDRSIZE:0] rdiff;
    logic              rinc;

    assign rinc      = r_req & ~rempty;
    assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rinc};
    assign rgraynext = (rbinnext >> 1) ^ rbinnext;
    assign raddr     = rbin[ADDRSIZE-1:0];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or
    // above it.
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wbin_s[i] = ^(rq2_wptr >> i);
        end
    end

    // Modular subtraction keeps the level correct across pointer wrap.
    assign rdiff = wbin_s - rbinnext;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            raempty <= 1'b1;
            rlevel  <= '0;
            rvalid  <= 1'b0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= (rgraynext == rq2_wptr);
            rlevel  <= rdiff;
            raempty <= (rdiff <= AE_TH);
            rvalid  <= rinc;
        end
    end

`ifdef RPTR_UNDERFLOW_EN
    // Set has priority over clear so a same-cycle underflow is never lost.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rerr <= 1'b0;
        end else if (r_req & rempty) begin
            rerr <= 1'b1;
        end else if (rerr_clr) begin
            rerr <= 1'b0;
        end
    end
`else
    logic unused_rerr_clr;
    assign unused_rerr_clr = rerr_clr;
    assign rerr = 1'b0;
`endif

endmodule
